dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported DataMemory.
// Each grant walks IDLE -> ACCESS -> DONE; illegal requests skip ACCESS and never touch the memory.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [1:0]  p0_size,
    input  logic [7:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [1:0]  p1_size,
    input  logic [7:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [7:0]  mem_A,
    output logic [31:0] mem_DI,
    output logic [1:0]  mem_Size,
    output logic        mem_RW,
    output logic        mem_E,
    input  logic [31:0] mem_DO,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        last_gnt;
    logic        lat_rw;
    logic        win;
    logic        w_rw;
    logic [1:0]  w_size;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_bad;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        win     = (p0_req && p1_req) ? ~last_gnt : p1_req;
        w_rw    = win ? p1_rw    : p0_rw;
        w_size  = win ? p1_size  : p0_size;
        w_addr  = win ? p1_addr  : p0_addr;
        w_wdata = win ? p1_wdata : p0_wdata;
        w_bad   = (w_size == 2'b11) ||
                  (w_size == 2'b01 && w_addr[0]) ||
                  (w_size == 2'b10 && w_addr[1:0] != 2'b00);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            lat_rw   <= 1'b0;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
            mem_A    <= '0;
            mem_DI   <= '0;
            mem_Size <= '0;
            mem_RW   <= 1'b0;
            mem_E    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        last_gnt <= win;
                        gnt_id   <= win;
                        lat_rw   <= w_rw;
                        if (w_bad) begin
                            // Error response goes straight out; rdata stays 0.
                            state <= DONE;
                            if (win) begin p1_ack <= 1'b1; p1_err <= 1'b1; end
                            else     begin p0_ack <= 1'b1; p0_err <= 1'b1; end
                        end else begin
                            state    <= ACCESS;
                            mem_A    <= w_addr;
                            mem_DI   <= w_wdata;
                            mem_Size <= w_size;
                            mem_RW   <= w_rw;
                            mem_E    <= w_rw;
                        end
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    mem_RW <= 1'b0;
                    mem_E  <= 1'b0;
                    if (gnt_id) begin
                        p1_ack   <= 1'b1;
                        p1_rdata <= lat_rw ? 32'd0 : mem_DO;
                    end else begin
                        p0_ack   <= 1'b1;
                        p0_rdata <= lat_rw ? 32'd0 : mem_DO;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    p0_ack   <= 1'b0;
                    p0_err   <= 1'b0;
                    p0_rdata <= '0;
                    p1_ack   <= 1'b0;
                    p1_err   <= 1'b0;
                    p1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
